// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT frame buffer.
package fft_pkg;

  localparam int N_POINTS_DEF = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int LOG2_N       = $clog2(N_POINTS_DEF);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational index bit-order reversal used for read addressing.
module fft_bitrev #(
  parameter int unsigned LOG2_N = 3
) (
  input  logic [LOG2_N-1:0] idx,
  output logic [LOG2_N-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < LOG2_N; i++) begin
      rev[i] = idx[LOG2_N-1-i];
    end
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Single-frame buffer: fills in natural order, drains in bit-reversed order.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        req_i,
  input  logic [DATA_W-1:0]           data_i,
  output logic                        ans_o,
  output logic                        req_o,
  input  logic                        ans_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [$clog2(N_POINTS)-1:0] addr_o,
  output logic                        last_o,
  output logic [7:0]                  frame_cnt_o
);

  localparam int unsigned AW = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_cnt, rd_cnt, rd_addr;
  logic [DATA_W-1:0] mem [N_POINTS];
  logic            wr_fire, rd_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  // Handshake outputs depend only on state (and en), never on req_i/ans_i.
  always_comb begin
    state_nxt = state;
    ans_o     = 1'b0;
    req_o     = 1'b0;
    case (state)
      FILL: begin
        ans_o = en;
        if (req_i && en && (wr_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        req_o = 1'b1;
        if (ans_i && (rd_cnt == LAST_IDX)) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign wr_fire = req_i & ans_o;
  assign rd_fire = req_o & ans_i;
  assign last_o  = (state == DRAIN) && (rd_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + 1'b1;
      end
      if (rd_fire) begin
        if (last_o) begin
          rd_cnt      <= '0;
          frame_cnt_o <= frame_cnt_o + 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt] <= data_i;
  end

  fft_bitrev #(.LOG2_N(AW)) u_bitrev (
    .idx (rd_cnt),
    .rev (rd_addr)
  );

  // rd_cnt is 0 outside DRAIN, so addr_o reads as 0 in FILL and reset.
  assign addr_o = rd_addr;
  assign data_o = mem[rd_addr];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer (N_POINTS=8, DATA_W=16).
module tb_fft_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req_i;
  logic [15:0] data_i;
  logic        ans_o;
  logic        req_o;
  logic        ans_i;
  logic [15:0] data_o;
  logic [2:0]  addr_o;
  logic        last_o;
  logic [7:0]  frame_cnt_o;

  fft_frame_buffer #(.N_POINTS(8), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_i       (req_i),
    .data_i      (data_i),
    .ans_o       (ans_o),
    .req_o       (req_o),
    .ans_i       (ans_i),
    .data_o      (data_o),
    .addr_o      (addr_o),
    .last_o      (last_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  a;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pops    = 0;
  logic [7:0]  exp_fc  = 8'd0;
  bit          ans_mode = 1'b0;
  int          rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ans_i driver: constant 1, or the 1,0,0 repeating pattern.
  initial begin
    int tog = 0;
    ans_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ans_mode) begin
        ans_i = (tog == 0);
        tog = (tog + 1) % 3;
      end else begin
        ans_i = 1'b1;
        tog = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    bit          held_v = 1'b0;
    bit          chk_fc = 1'b0;
    logic [15:0] held_d;
    logic [2:0]  held_a;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (chk_fc) begin
          chk("frame_cnt", frame_cnt_o, exp_fc);
          chk("post_frame_req_o", req_o, 1'b0);
          chk("post_frame_ans_o", ans_o, en);
          chk_fc = 1'b0;
        end
        if (held_v) begin
          if (req_o) begin
            chk("hold_data_o", data_o, held_d);
            chk("hold_addr_o", addr_o, held_a);
          end
          held_v = 1'b0;
        end
        if (req_o) begin
          chk("drain_ans_o", ans_o, 1'b0);
          if (ans_i) begin
            if (q.size() == 0) begin
              chk("unexpected_output", data_o, 32'hFFFF_FFFF);
            end else begin
              e = q.pop_front();
              chk("data_o", data_o, e.d);
              chk("addr_o", addr_o, e.a);
              chk("last_o", last_o, e.l);
              pops++;
              if (e.l) begin
                exp_fc = exp_fc + 8'd1;
                chk_fc = 1'b1;
              end
            end
          end else begin
            held_v = 1'b1;
            held_d = data_o;
            held_a = addr_o;
          end
        end else if (last_o) begin
          chk("last_o_without_req", last_o, 1'b0);
        end
      end else begin
        held_v = 1'b0;
        chk_fc = 1'b0;
      end
    end
  end

  task automatic send_sample(input logic [15:0] d, input bit is_last);
    int n = 0;
    req_i  = 1'b1;
    data_i = d;
    forever begin
      @(negedge clk);
      if (ans_o) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_last) chk("latency_req_o", req_o, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] base, input int gap_at);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.d = base + 16'(rev8[k]);
      e.a = 3'(rev8[k]);
      e.l = (k == 7);
      q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        en     = 1'b0;
        req_i  = 1'b1;
        data_i = 16'hDEAD;
        repeat (5) begin
          @(negedge clk);
          chk("gap_ans_o", ans_o, 1'b0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
      end
      send_sample(base + 16'(k), k == 7);
    end
    req_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    int n;
    rst    = 1'b0;
    en     = 1'b1;
    req_i  = 1'b0;
    data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_last_o", last_o, 1'b0);
    chk("rst_addr_o", addr_o, 3'd0);
    chk("rst_ans_o", ans_o, 1'b1);
    chk("rst_frame_cnt", frame_cnt_o, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, bit-reversed drain.
    send_frame(16'h0000, -1);
    wait_drain();
    chk("frame_cnt_after_first", frame_cnt_o, 8'd1);

    // en gap after 3 accepted samples.
    send_frame(16'h0010, 3);
    wait_drain();

    // Stalled drain, with the next frame already waiting upstream.
    ans_mode = 1'b1;
    send_frame(16'h0020, -1);
    send_frame(16'h0030, -1);
    wait_drain();
    ans_mode = 1'b0;
    chk("frame_cnt_after_stall", frame_cnt_o, 8'd4);

    // Asynchronous reset after 3 outputs of a drain.
    send_frame(16'h0200, -1);
    n = 0;
    while (pops < 35 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("pops_before_reset", pops, 35);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_req_o", req_o, 1'b0);
    chk("async_rst_last_o", last_o, 1'b0);
    chk("async_rst_addr_o", addr_o, 3'd0);
    chk("async_rst_frame_cnt", frame_cnt_o, 8'd0);
    chk("async_rst_ans_o", ans_o, 1'b1);
    q.delete();
    exp_fc = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'h0100, -1);
    wait_drain();
    chk("frame_cnt_after_reset", frame_cnt_o, 8'd1);

    // 256 back-to-back frames: counter wraps through 0 back to 1.
    for (int f = 0; f < 256; f++) begin
      send_frame(16'h1000 + 16'(f * 8), -1);
    end
    wait_drain();
    chk("frame_cnt_wrap", frame_cnt_o, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
